// File: rtl/echo_remove_if.sv
// Sample bus between the ADC interface, the de-echo filter and the DAC.
// The ADC side (master) drives the level-qualified sample; the filter (slave) returns the DAC code.
interface echo_remove_if;
  logic       data_valid;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       out_valid;
  logic       primed;

  modport master (
    output data_valid, data_in,
    input  data_out, out_valid, primed
  );

  modport slave (
    input  data_valid, data_in,
    output data_out, out_valid, primed
  );
endinterface

// File: rtl/echo_remove.sv
// De-echo filter: x[n] = y[n] + y[n-DEPTH]/2, undoing the feedback echo stage.
// Two stages: S1 captures the sample and its delayed partner, S2 produces the clamped DAC code.
module echo_remove #(
  parameter int         DEPTH      = 1024,
  parameter logic [9:0] ADC_OFFSET = 10'h181,
  parameter logic [9:0] DAC_OFFSET = 10'h200
) (
  input logic         sysclk,
  input logic         reset,
  echo_remove_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          dv_q;
  logic          strobe;
  logic [9:0]    x;
  logic [9:0]    rd_data;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic          primed;
  logic          s1_valid;
  logic [9:0]    x_r;
  logic [9:0]    d_r;
  logic [10:0]   sum;
  logic [9:0]    clamped;
  logic [9:0]    mem [DEPTH];

  assign strobe     = bus.data_valid & ~dv_q;
  assign x          = bus.data_in - ADC_OFFSET;
  assign rd_data    = mem[wptr];
  assign primed     = (count == CW'(DEPTH));
  assign bus.primed = primed;

  // NOTE: the delay line has no reset; stale contents are masked by the fill counter instead.
  always_ff @(posedge sysclk) begin
    if (strobe) mem[wptr] <= x;
  end

  // S1: the read above sees the old word, so d_r is the sample from DEPTH strobes ago.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      dv_q     <= 1'b0;
      s1_valid <= 1'b0;
      x_r      <= '0;
      d_r      <= '0;
      wptr     <= '0;
      count    <= '0;
    end else begin
      dv_q     <= bus.data_valid;
      s1_valid <= strobe;
      if (strobe) begin
        x_r  <= x;
        d_r  <= primed ? rd_data : '0;
        wptr <= wptr + 1'b1;
        if (!primed) count <= count + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum     = {x_r[9], x_r} + {{2{d_r[9]}}, d_r[9:1]};
    clamped = sum[9:0];
    case (sum[10:9])
      2'b01:   clamped = 10'h1FF;
      2'b10:   clamped = 10'h200;
      default: clamped = sum[9:0];
    endcase
  end

  // S2: data_out holds between strobes; out_valid is a one-cycle strobe.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      bus.data_out  <= DAC_OFFSET;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) bus.data_out <= clamped + DAC_OFFSET;
    end
  end

endmodule

// File: tb/tb_echo_remove.sv
// Bench for echo_remove at DEPTH=4 and DEPTH=2, checked against a queue-based model
// of x[n] = clamp(y[n] + floor(y[n-DEPTH]/2)).
module tb_echo_remove;

  logic sysclk = 1'b0;
  logic reset;
  always #5 sysclk = ~sysclk;

  echo_remove_if if4 ();
  echo_remove_if if2 ();

  echo_remove #(.DEPTH(4)) u4 (.sysclk(sysclk), .reset(reset), .bus(if4));
  echo_remove #(.DEPTH(2)) u2 (.sysclk(sysclk), .reset(reset), .bus(if2));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // observed {primed, data_out} per out_valid, expected ones, and input history since reset
  logic [10:0] act4[$], act2[$], exp4[$], exp2[$];
  int          hist4[$], hist2[$], t2[$];

  always @(negedge sysclk) begin
    cyc++;
    if (if4.out_valid) act4.push_back({if4.primed, if4.data_out});
    if (if2.out_valid) begin
      act2.push_back({if2.primed, if2.data_out});
      t2.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [10:0] model(input int h[$], input int depth, input int x);
    int n, d, s;
    logic p;
    n = h.size();
    d = (n >= depth) ? h[n - depth] : 0;
    s = x + (d - (d & 1)) / 2;
    if (s > 511)  s = 511;
    if (s < -512) s = -512;
    p = (n + 1 >= depth);
    return {p, 10'((s + 512) & 1023)};
  endfunction

  function automatic logic [9:0] code_of(input int x);
    return 10'((x + 'h181) & 1023);
  endfunction

  task automatic expect_sample(input int which, input int x);
    if (which == 4) begin
      exp4.push_back(model(hist4, 4, x));
      hist4.push_back(x);
    end else begin
      exp2.push_back(model(hist2, 2, x));
      hist2.push_back(x);
    end
  endtask

  task automatic set_in(input int which, input logic dv, input logic [9:0] code);
    if (which == 4) begin
      if4.data_valid = dv;
      if4.data_in    = code;
    end else begin
      if2.data_valid = dv;
      if2.data_in    = code;
    end
  endtask

  // called at a negedge; returns at a negedge
  task automatic drive(input int which, input int x, input int hi, input int lo);
    expect_sample(which, x);
    set_in(which, 1'b1, code_of(x));
    repeat (hi) @(negedge sysclk);
    set_in(which, 1'b0, code_of(x));
    repeat (lo) @(negedge sysclk);
  endtask

  task automatic clear_all();
    act4.delete(); act2.delete(); exp4.delete(); exp2.delete();
    hist4.delete(); hist2.delete(); t2.delete();
  endtask

  task automatic pulse_reset();
    @(negedge sysclk);
    #2 reset = 1'b1;
    clear_all();
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic check_stream(input int which, input string tag);
    logic [10:0] a[$], e[$];
    int k;
    k = 0;
    while (((which == 4) ? (act4.size() < exp4.size()) : (act2.size() < exp2.size())) && k < 40) begin
      @(negedge sysclk);
      k++;
    end
    repeat (3) @(negedge sysclk);
    if (which == 4) begin
      a = act4; e = exp4; act4.delete(); exp4.delete();
    end else begin
      a = act2; e = exp2; act2.delete(); exp2.delete();
    end
    check($sformatf("%s_count", tag), a.size(), e.size());
    for (int i = 0; i < a.size() && i < e.size(); i++)
      check($sformatf("%s[%0d]", tag, i), a[i], e[i]);
  endtask

  initial begin
    int xs[$];
    reset = 1'b1;
    set_in(4, 1'b0, 10'h0);
    set_in(2, 1'b0, 10'h0);
    #12;
    check("reset_data_out", if4.data_out, 10'h200);
    check("reset_out_valid", if4.out_valid, 1'b0);
    check("reset_primed", if4.primed, 1'b0);
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);

    // pass-through before priming, with exact latency and a long high level
    expect_sample(4, 16);
    set_in(4, 1'b1, code_of(16));
    @(posedge sysclk); #1;
    check("lat_e0_valid", if4.out_valid, 1'b0);
    @(posedge sysclk); #1;
    check("lat_e1_valid", if4.out_valid, 1'b1);
    check("lat_e1_data", if4.data_out, 10'h210);
    @(posedge sysclk); #1;
    check("lat_e2_valid", if4.out_valid, 1'b0);
    check("lat_e2_hold", if4.data_out, 10'h210);
    repeat (8) @(negedge sysclk);
    set_in(4, 1'b0, code_of(16));
    repeat (2) @(negedge sysclk);
    check_stream(4, "passthru");

    // impulse
    pulse_reset();
    xs = '{100, 0, 0, 0, 0, 0};
    foreach (xs[i]) drive(4, xs[i], 1, 2);
    check_stream(4, "impulse");

    // saturation both ways
    pulse_reset();
    repeat (5) drive(4, 400, 1, 1);
    check_stream(4, "sat_pos");
    pulse_reset();
    repeat (5) drive(4, -400, 2, 1);
    check_stream(4, "sat_neg");

    // maximum rate at DEPTH=2
    pulse_reset();
    xs = '{10, 20, 30, 40};
    foreach (xs[i]) drive(2, xs[i], 1, 1);
    begin
      int ts[$];
      repeat (4) @(negedge sysclk);
      ts = t2;
      check("maxrate_pulses", ts.size(), 4);
      for (int i = 1; i < ts.size(); i++)
        check($sformatf("maxrate_gap%0d", i), ts[i] - ts[i-1], 2);
    end
    check_stream(2, "maxrate");

    // reset while a sample is in flight
    pulse_reset();
    repeat (6) drive(4, int'($urandom_range(1023)) - 512, 1, 1);
    check_stream(4, "pre_midreset");
    set_in(4, 1'b1, code_of(7));
    @(posedge sysclk);
    #2 reset = 1'b1;
    #1;
    check("midreset_data_out", if4.data_out, 10'h200);
    check("midreset_out_valid", if4.out_valid, 1'b0);
    check("midreset_primed", if4.primed, 1'b0);
    clear_all();
    @(negedge sysclk);
    set_in(4, 1'b0, code_of(7));
    @(negedge sysclk);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    check("midreset_no_valid", act4.size(), 0);
    drive(4, 50, 1, 1);
    check_stream(4, "after_midreset");

    // data_valid already high at reset release
    @(negedge sysclk);
    #2 reset = 1'b1;
    clear_all();
    expect_sample(4, 3);
    set_in(4, 1'b1, code_of(3));
    @(negedge sysclk);
    reset = 1'b0;
    repeat (10) @(negedge sysclk);
    set_in(4, 1'b0, code_of(3));
    repeat (2) @(negedge sysclk);
    check_stream(4, "high_at_release");

    // random streams at both depths
    pulse_reset();
    repeat (40) drive(4, int'($urandom_range(1023)) - 512, int'($urandom_range(3, 1)), int'($urandom_range(3, 1)));
    check_stream(4, "rand4");
    repeat (40) drive(2, int'($urandom_range(1023)) - 512, int'($urandom_range(3, 1)), int'($urandom_range(3, 1)));
    check_stream(2, "rand2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
